hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands per instruction (1..4).
REQ-003 SHALL have parameter MD_LAT, default 4, multiply/divide latency in cycles (2..15).
REQ-004 SHALL have ports, one per line: name  direction  width  meaning:
- clk  in  1  single clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- src_d  in  NUM_SRC*ADDR_W  D-stage source addresses, slot i at bits [i*ADDR_W +: ADDR_W].
- src_e  in  NUM_SRC*ADDR_W  E-stage source addresses, same packing.
- branch_d  in  1  D instruction resolves a branch in D.
- wr_addr_e  in  ADDR_W  E destination address.
- we_e  in  1  E writes the regfile.
- load_e  in  1  E is a load.
- md_start_e  in  1  E launches a multi-cycle mul/div.
- wr_addr_m  in  ADDR_W  M destination address.
- we_m  in  1  M writes the regfile.
- load_m  in  1  M is a load.
- wr_addr_w  in  ADDR_W  W destination address.
- we_w  in  1  W writes the regfile.
- fwd_d  out  NUM_SRC  per-slot D forward-from-M select.
- fwd_e  out  2*NUM_SRC  per-slot E select: 00 regfile, 01 M, 10 W.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold F/D register.
- flush_e  out  1  insert bubble into E.
- md_busy  out  1  mul/div in flight.

Function
REQ-005 SHALL treat address 0 as never matching in all comparisons.
REQ-006 SHALL drive fwd_e slot i = 01 if src_e[i]==wr_addr_m and we_m, else 10 if src_e[i]==wr_addr_w and we_w, else 00; M has priority over W.
REQ-007 SHALL drive fwd_d slot i = 1 iff src_d[i]==wr_addr_m and we_m and not load_m.
REQ-008 SHALL raise load-use hazard when load_e and we_e and any src_d[i]==wr_addr_e.
REQ-009 SHALL raise branch hazard when branch_d and any src_d[i] matches wr_addr_e with we_e, or wr_addr_m with we_m and load_m.
REQ-010 SHALL hold a down-counter and a destination register; md_start_e with not flush_e loads counter MD_LAT-1 and captures wr_addr_e.
REQ-011 SHALL decrement the counter by 1 each cycle while nonzero; md_busy = counter != 0.
REQ-012 SHALL raise md hazard when md_busy and (any src_d[i] equals the captured destination, or D issues md_start, inferred as branch_d=0 not applicable: D-stage md issue is signalled by md_start_e arriving while md_busy, which SHALL be ignored and not reload the counter).
REQ-013 SHALL assert stall_f = stall_d = flush_e = OR of load-use, branch and md hazards, combinationally, same cycle.
REQ-014 SHALL, on the cycle the counter reaches 0, deassert md_busy so a dependent D instruction issues next cycle.

Reset
REQ-015 SHALL, while rst high at a clk edge, clear counter and captured destination to 0; md_busy, stall_f, stall_d, flush_e SHALL be 0 the cycle after reset regardless of inputs except live load-use/branch hazards.
REQ-016 SHALL abort an in-flight mul/div on reset mid-operation with no residual stall.

Configuration
REQ-017 SHALL compile D-stage forwarding only when HAZARD_DFWD_EN is defined; without it fwd_d SHALL be all 0 and branch hazard SHALL also cover src_d matching wr_addr_m with we_m for any instruction type.

Structure
REQ-018 SHALL place select encodings FWD_RF/FWD_M/FWD_W and default ADDR_W in shared package hazard_pkg.
REQ-019 SHALL implement counter and destination capture in sub-module md_scoreboard.

Verification
REQ-020 src_e[0]=3, wr_addr_m=3, we_m=1, wr_addr_w=3, we_w=1 -> fwd_e slot0 = 01.
REQ-021 load_e=1, we_e=1, wr_addr_e=7, src_d[1]=7 -> stall_f=stall_d=flush_e=1 same cycle; src_d=0 with wr_addr_e=0 -> no stall.
REQ-022 MD_LAT=4, md_start_e dst 9, then src_d[0]=9 -> stall for exactly 3 cycles, md_busy low on 4th.
REQ-023 branch_d=1, src_d[0]=5, we_m=1, load_m=0, wr_addr_m=5 -> fwd_d[0]=1, no stall (with HAZARD_DFWD_EN); stall without it.
REQ-024 rst asserted mid mul/div -> md_busy=0 next cycle, no stall on dependent source.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared forwarding-select encodings and default address width for the hazard unit.
package hazard_pkg;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwdSel_e;
endpackage

// File: rtl/md_scoreboard.sv
// Multi-cycle mul/div tracker: a down-counter plus the destination it will write.
module md_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dstIn,
  output logic              busy,
  output logic [ADDR_W-1:0] dst
);
  localparam int CNT_W = 4;

  logic [CNT_W-1:0]  countReg, countNext;
  logic [ADDR_W-1:0] dstReg, dstNext;

  // A launch while an operation is already in flight is ignored, never reloads.
  always_comb begin
    countNext = countReg;
    dstNext   = dstReg;
    if (countReg != '0) begin
      countNext = countReg - CNT_W'(1);
    end else if (start) begin
      countNext = CNT_W'(MD_LAT - 1);
      dstNext   = dstIn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      countReg <= '0;
      dstReg   <= '0;
    end else begin
      countReg <= countNext;
      dstReg   <= dstNext;
    end
  end

  assign busy = (countReg != '0);
  assign dst  = dstReg;
endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard detection and operand forwarding; define HAZARD_DFWD_EN to enable
// D-stage forwarding from M (otherwise branches stall on any M producer).
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] src_d,
  input  logic [NUM_SRC*ADDR_W-1:0] src_e,
  input  logic                      branch_d,
  input  logic [ADDR_W-1:0]         wr_addr_e,
  input  logic                      we_e,
  input  logic                      load_e,
  input  logic                      md_start_e,
  input  logic [ADDR_W-1:0]         wr_addr_m,
  input  logic                      we_m,
  input  logic                      load_m,
  input  logic [ADDR_W-1:0]         wr_addr_w,
  input  logic                      we_w,
  output logic [NUM_SRC-1:0]        fwd_d,
  output logic [2*NUM_SRC-1:0]      fwd_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_e,
  output logic                      md_busy
);
  logic [NUM_SRC-1:0] hitE, hitM, hitMd;
  logic               mdBusy;
  logic [ADDR_W-1:0]  mdDst;
  logic               branchMCond;
  logic               loadUseHaz, branchHaz, mdHaz, hazard;

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic addrHit(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gSlot
      logic [ADDR_W-1:0] srcD, srcE;
      assign srcD      = src_d[gi*ADDR_W +: ADDR_W];
      assign srcE      = src_e[gi*ADDR_W +: ADDR_W];
      assign hitE[gi]  = addrHit(srcD, wr_addr_e);
      assign hitM[gi]  = addrHit(srcD, wr_addr_m);
      assign hitMd[gi] = addrHit(srcD, mdDst);
      assign fwd_e[2*gi +: 2] = (we_m && addrHit(srcE, wr_addr_m)) ? FWD_M :
                                (we_w && addrHit(srcE, wr_addr_w)) ? FWD_W : FWD_RF;
`ifdef HAZARD_DFWD_EN
      assign fwd_d[gi] = we_m && !load_m && hitM[gi];
`else
      assign fwd_d[gi] = 1'b0;
`endif
    end
  endgenerate

  // Without the D-stage bypass, any M producer blocks a branch; with it, only loads do.
`ifdef HAZARD_DFWD_EN
  assign branchMCond = we_m && load_m;
`else
  assign branchMCond = we_m;
`endif

  assign loadUseHaz = load_e && we_e && (|hitE);
  assign branchHaz  = branch_d && ((we_e && (|hitE)) || (branchMCond && (|hitM)));
  assign mdHaz      = mdBusy && ((|hitMd) || md_start_e);
  assign hazard     = loadUseHaz || branchHaz || mdHaz;

  md_scoreboard #(
    .ADDR_W (ADDR_W),
    .MD_LAT (MD_LAT)
  ) uMdScoreboard (
    .clk   (clk),
    .rst   (rst),
    .start (md_start_e && !hazard),
    .dstIn (wr_addr_e),
    .busy  (mdBusy),
    .dst   (mdDst)
  );

  assign stall_f = hazard;
  assign stall_d = hazard;
  assign flush_e = hazard;
  assign md_busy = mdBusy;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized and directed checks of hazard_forward_unit against a cycle-count reference model.
module tb_hazard_forward_unit;
  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NS*AW-1:0] src_d, src_e;
  logic branch_d, we_e, load_e, md_start_e, we_m, load_m, we_w;
  logic [AW-1:0] wr_addr_e, wr_addr_m, wr_addr_w;
  logic [NS-1:0] fwd_d;
  logic [2*NS-1:0] fwd_e;
  logic stall_f, stall_d, flush_e, md_busy;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int mdEnd = 0;   // model: mul/div busy while cycle < mdEnd
  int mdDst = 0;
  bit expHaz;

  always #5 clk = ~clk;

  hazard_forward_unit #(.ADDR_W(AW), .NUM_SRC(NS), .MD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .src_d(src_d), .src_e(src_e), .branch_d(branch_d),
    .wr_addr_e(wr_addr_e), .we_e(we_e), .load_e(load_e), .md_start_e(md_start_e),
    .wr_addr_m(wr_addr_m), .we_m(we_m), .load_m(load_m),
    .wr_addr_w(wr_addr_w), .we_w(we_w),
    .fwd_d(fwd_d), .fwd_e(fwd_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_e(flush_e), .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input int a, input int b);
    return (a != 0) && (a == b);
  endfunction

  task automatic clearIn();
    rst = 0; src_d = '0; src_e = '0; branch_d = 0; we_e = 0; load_e = 0;
    md_start_e = 0; we_m = 0; load_m = 0; we_w = 0;
    wr_addr_e = '0; wr_addr_m = '0; wr_addr_w = '0;
  endtask

  task automatic setSrcD(input int slot, input int a);
    src_d[slot*AW +: AW] = AW'(a);
  endtask

  // Evaluate the reference model for the current inputs and compare every output.
  task automatic evalNow(input string name);
    int sd[NS];
    int se[NS];
    bit busy, luse, br, md;
    logic [NS-1:0] eD;
    logic [2*NS-1:0] eE;
    #2;
    busy = (cycle < mdEnd);
    luse = 0; br = 0; md = 0; eD = '0; eE = '0;
    for (int i = 0; i < NS; i++) begin
      sd[i] = int'(src_d[i*AW +: AW]);
      se[i] = int'(src_e[i*AW +: AW]);
      if (we_m && hit(se[i], int'(wr_addr_m)))      eE[2*i +: 2] = 2'b01;
      else if (we_w && hit(se[i], int'(wr_addr_w))) eE[2*i +: 2] = 2'b10;
      if (load_e && we_e && hit(sd[i], int'(wr_addr_e))) luse = 1;
      if (branch_d && ((we_e && hit(sd[i], int'(wr_addr_e))) ||
                       (we_m && load_m && hit(sd[i], int'(wr_addr_m))))) br = 1;
`ifdef HAZARD_DFWD_EN
      if (we_m && !load_m && hit(sd[i], int'(wr_addr_m))) eD[i] = 1'b1;
`else
      if (branch_d && we_m && hit(sd[i], int'(wr_addr_m))) br = 1;
`endif
      if (busy && hit(sd[i], mdDst)) md = 1;
    end
    if (busy && md_start_e) md = 1;
    expHaz = luse | br | md;
    chk({name, ".fwd_e"},   32'(fwd_e),   32'(eE));
    chk({name, ".fwd_d"},   32'(fwd_d),   32'(eD));
    chk({name, ".stall_f"}, 32'(stall_f), 32'(expHaz));
    chk({name, ".stall_d"}, 32'(stall_d), 32'(expHaz));
    chk({name, ".flush_e"}, 32'(flush_e), 32'(expHaz));
    chk({name, ".md_busy"}, 32'(md_busy), 32'(busy));
    $display("cyc=%0d %s src_d=%h src_e=%h haz=%0b busy=%0b fwd_e=%b fwd_d=%b",
             cycle, name, src_d, src_e, expHaz, busy, fwd_e, fwd_d);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (rst) begin
      mdEnd = 0;
      mdDst = 0;
    end else if (!(cycle < mdEnd) && md_start_e && !expHaz) begin
      mdEnd = cycle + LAT;
      mdDst = int'(wr_addr_e);
    end
    cycle++;
  endtask

  initial begin
    clearIn();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    clearIn();
    cycle = 1;

    evalNow("reset");
    chk("reset.md_busy0", 32'(md_busy), 32'd0);
    advance();

    // M beats W on a shared destination
    clearIn(); src_e[AW-1:0] = 5'd3; wr_addr_m = 5'd3; we_m = 1; wr_addr_w = 5'd3; we_w = 1;
    evalNow("mprio");
    chk("mprio.slot0", 32'(fwd_e[1:0]), 32'h1);
    advance();

    clearIn(); load_e = 1; we_e = 1; wr_addr_e = 5'd7; setSrcD(1, 7);
    evalNow("loaduse");
    chk("loaduse.stall", 32'(stall_f & stall_d & flush_e), 32'd1);
    advance();

    clearIn(); load_e = 1; we_e = 1;
    evalNow("zeroaddr");
    chk("zeroaddr.stall", 32'(stall_f), 32'd0);
    advance();

    // mul/div to r9, dependent reader stalls exactly LAT-1 cycles
    clearIn(); md_start_e = 1; wr_addr_e = 5'd9;
    evalNow("mdstart");
    advance();
    for (int k = 0; k < LAT; k++) begin
      clearIn(); setSrcD(0, 9);
      evalNow($sformatf("mddep%0d", k));
      chk($sformatf("mddep%0d.stall", k), 32'(stall_d), 32'(k < LAT - 1));
      chk($sformatf("mddep%0d.busy", k), 32'(md_busy), 32'(k < LAT - 1));
      advance();
    end

    clearIn(); branch_d = 1; setSrcD(0, 5); we_m = 1; wr_addr_m = 5'd5;
    evalNow("brfwd");
`ifdef HAZARD_DFWD_EN
    chk("brfwd.fwd_d0", 32'(fwd_d[0]), 32'd1);
    chk("brfwd.stall", 32'(stall_f), 32'd0);
`else
    chk("brfwd.fwd_d0", 32'(fwd_d[0]), 32'd0);
    chk("brfwd.stall", 32'(stall_f), 32'd1);
`endif
    advance();

    // reset in the middle of a mul/div
    clearIn(); md_start_e = 1; wr_addr_e = 5'd9;
    evalNow("mdabort.start");
    advance();
    clearIn(); rst = 1; setSrcD(0, 9);
    evalNow("mdabort.rst");
    advance();
    clearIn(); setSrcD(0, 9);
    evalNow("mdabort.after");
    chk("mdabort.busy", 32'(md_busy), 32'd0);
    chk("mdabort.stall", 32'(stall_f), 32'd0);
    advance();

    for (int n = 0; n < 400; n++) begin
      clearIn();
      rst        = ($urandom_range(0, 49) == 0);
      md_start_e = ($urandom_range(0, 5) == 0);
      branch_d   = ($urandom_range(0, 2) == 0);
      we_e = 1'($urandom); load_e = 1'($urandom);
      we_m = 1'($urandom); load_m = 1'($urandom); we_w = 1'($urandom);
      wr_addr_e = AW'($urandom_range(0, 7));
      wr_addr_m = AW'($urandom_range(0, 7));
      wr_addr_w = AW'($urandom_range(0, 7));
      for (int i = 0; i < NS; i++) begin
        src_d[i*AW +: AW] = AW'($urandom_range(0, 7));
        src_e[i*AW +: AW] = AW'($urandom_range(0, 7));
      end
      evalNow("rand");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
